// File: rtl/mult_cell_arbiter.sv
// Round-robin arbiter sharing one pipelined 32x32 multiplier cell among NUM_REQ requesters.
// Optional build macro MULT_ARB_PERF_CNT_EN adds an accepted-operation counter (perf_clr/perf_ops).
module mult_cell_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int MUL_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_en,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_src1,
  input  logic [NUM_REQ*32-1:0] req_src2,
  output logic [31:0]           mul_src1,
  output logic [31:0]           mul_src2,
  input  logic [31:0]           mul_result,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_result,
  output logic                  busy
`ifdef MULT_ARB_PERF_CNT_EN
  ,
  input  logic                  perf_clr,
  output logic [31:0]           perf_ops
`endif
);

  localparam int ID_W  = (NUM_REQ > 2) ? 2 : 1;
  localparam int TAG_N = MUL_LATENCY + 1;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic [ID_W:0]      cand;
  logic [ID_W-1:0]    next_ptr;
  logic [31:0]        sel_src1;
  logic [31:0]        sel_src2;
  tag_t               tag_q [TAG_N];
  tag_t               tag_out;
  logic [NUM_REQ-1:0] rsp_onehot;

  // Round-robin search starting at rr_ptr; reset and issue_en both suppress any grant.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    if (issue_en && !reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (cand >= (ID_W+1)'(NUM_REQ))
          cand = cand - (ID_W+1)'(NUM_REQ);
        if (!grant_any && req_valid[cand[ID_W-1:0]]) begin
          grant_any = 1'b1;
          grant_id  = cand[ID_W-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_src1  = '0;
    sel_src2  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_any && grant_id == ID_W'(i)) begin
        req_ready[i] = 1'b1;
        sel_src1     = req_src1[32*i +: 32];
        sel_src2     = req_src2[32*i +: 32];
      end
    end
  end

  assign next_ptr = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      mul_src1 <= '0;
      mul_src2 <= '0;
    end else if (grant_any) begin
      rr_ptr   <= next_ptr;
      mul_src1 <= sel_src1;
      mul_src2 <= sel_src2;
    end
  end

  // NOTE: the tag array is reset (unlike a data RAM) so a reset discards every in-flight op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAG_N; i++)
        tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {grant_any, grant_id};
      for (int i = 1; i < TAG_N; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  // The last tag stage lines up with mul_result from the cell.
  assign tag_out = tag_q[TAG_N-1];

  always_comb begin
    rsp_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_onehot[i] = tag_out.vld && (tag_out.id == ID_W'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= '0;
      rsp_result <= '0;
    end else begin
      rsp_valid <= rsp_onehot;
      if (tag_out.vld)
        rsp_result <= mul_result;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < TAG_N; i++)
      busy = busy | tag_q[i].vld;
  end

`ifdef MULT_ARB_PERF_CNT_EN
  // Clear wins over a same-edge accept; the counter wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      perf_ops <= '0;
    else if (perf_clr)
      perf_ops <= '0;
    else if (grant_any)
      perf_ops <= perf_ops + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mult_cell_arbiter.sv
// Self-checking bench for mult_cell_arbiter: behavioural mult cell, round-robin grant model
// and a response scoreboard that checks requester, product and arrival cycle.
module tb_mult_cell_arbiter;

  localparam int NUM_REQ     = 3;
  localparam int MUL_LATENCY = 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  issue_en;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_src1;
  logic [NUM_REQ*32-1:0] req_src2;
  logic [31:0]           mul_src1;
  logic [31:0]           mul_src2;
  logic [31:0]           mul_result;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_result;
  logic                  busy;
`ifdef MULT_ARB_PERF_CNT_EN
  logic                  perf_clr;
  logic [31:0]           perf_ops;
`endif

  mult_cell_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LATENCY(MUL_LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .issue_en   (issue_en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .mul_src1   (mul_src1),
    .mul_src2   (mul_src2),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .busy       (busy)
`ifdef MULT_ARB_PERF_CNT_EN
    ,
    .perf_clr   (perf_clr),
    .perf_ops   (perf_ops)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural multiplier cell: MUL_LATENCY register stages, low 32 bits of the product.
  logic [31:0] cell_pipe [MUL_LATENCY];
  always @(posedge clk) begin
    cell_pipe[0] <= mul_src1 * mul_src2;
    for (int k = 1; k < MUL_LATENCY; k++)
      cell_pipe[k] <= cell_pipe[k-1];
  end
  assign mul_result = cell_pipe[MUL_LATENCY-1];

  typedef struct {
    int          id;
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_pass;
  int   cyc;
  int   ptr_model;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every response must match the oldest expected entry on its due cycle.
  exp_t               mon_e;
  logic [NUM_REQ-1:0] mon_oh;
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (rsp_valid !== '0) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL rsp_unexpected: rsp_valid=%b rsp_result=%h with nothing outstanding (cyc %0d)",
                   rsp_valid, rsp_result, cyc);
        end else begin
          mon_e  = sb.pop_front();
          mon_oh = NUM_REQ'(1) << mon_e.id;
          if (rsp_valid !== mon_oh || rsp_result !== mon_e.val || cyc != mon_e.due)
            $display("FAIL rsp_match: rsp_valid=%b rsp_result=%h cyc=%0d, expected %b %h cyc=%0d",
                     rsp_valid, rsp_result, cyc, mon_oh, mon_e.val, mon_e.due);
          else
            n_pass++;
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_checks++;
        mon_e = sb.pop_front();
        $display("FAIL rsp_missing: no rsp_valid by cyc %0d, expected id %0d result %h at cyc %0d",
                 cyc, mon_e.id, mon_e.val, mon_e.due);
      end
    end
  end

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_src1[32*i +: 32] = a;
    req_src2[32*i +: 32] = b;
  endtask

  // One clock of stimulus: drive, check the grant against the bench model, push expected result.
  task automatic cycle(input logic en, input logic [NUM_REQ-1:0] v, input string name);
    logic [NUM_REQ-1:0] exp_rdy;
    logic [63:0]        p;
    exp_t               e;
    int                 g;
    int                 idx;
    @(negedge clk);
    issue_en  = en;
    req_valid = v;
    #1;
    g = -1;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (ptr_model + k) % NUM_REQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
    n_checks++;
    if (req_ready !== exp_rdy)
      $display("FAIL %s grant: req_ready=%b expected %b", name, req_ready, exp_rdy);
    else
      n_pass++;
    if (g >= 0) begin
      p     = {32'b0, req_src1[32*g +: 32]} * {32'b0, req_src2[32*g +: 32]};
      e.id  = g;
      e.val = p[31:0];
      e.due = cyc + MUL_LATENCY + 2;
      sb.push_back(e);
      ptr_model = (g + 1) % NUM_REQ;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, '0, "idle");
  endtask

  task automatic apply_reset;
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    issue_en  = 1'b0;
    sb.delete();
    ptr_model = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    issue_en  = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, 32'h11 * (i + 1), 32'h7);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_result !== '0 || busy !== 1'b0 ||
        mul_src1 !== '0 || mul_src2 !== '0)
      $display("FAIL reset_state: ready=%b rsp_valid=%b rsp_result=%h busy=%b src1=%h src2=%h, expected all zero",
               req_ready, rsp_valid, rsp_result, busy, mul_src1, mul_src2);
    else
      n_pass++;
    req_valid = '0;
    ptr_model = 0;
    reset     = 1'b0;
  endtask

  task automatic test_round_robin;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, 32'd10 + i, 32'd100 + i);
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NUM_REQ; i++) set_ops(i, 32'd10 * (n + 1) + i, 32'd100 + 7 * i);
      cycle(1'b1, '1, "round_robin");
    end
    idle(4);
  endtask

  task automatic test_single;
    set_ops(0, 32'd3, 32'd5);
    cycle(1'b1, 3'b001, "single_accept");
    n_checks++;
    if (busy !== 1'b1) $display("FAIL single_busy1: busy=%b expected 1", busy); else n_pass++;
    idle(1);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL single_busy2: busy=%b expected 1", busy); else n_pass++;
    idle(1);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL single_busy_end: busy=%b expected 0", busy); else n_pass++;
    idle(1);
    n_checks++;
    if (rsp_valid !== '0 || rsp_result !== 32'd15)
      $display("FAIL single_hold: rsp_valid=%b rsp_result=%h expected 000 0000000f", rsp_valid, rsp_result);
    else
      n_pass++;
  endtask

  task automatic test_wrap;
    set_ops(1, 32'hFFFF_FFFF, 32'd2);
    cycle(1'b1, 3'b010, "wrap_ff");
    set_ops(2, 32'h0001_0000, 32'h0001_0000);
    cycle(1'b1, 3'b100, "wrap_zero");
    idle(4);
  endtask

  task automatic test_issue_gate;
    set_ops(0, 32'd1234, 32'd5678);
    set_ops(1, 32'd9, 32'd9);
    cycle(1'b1, 3'b001, "gate_accept");
    cycle(1'b0, '1, "gate_blocked");
    n_checks++;
    if (busy !== 1'b1) $display("FAIL gate_busy: busy=%b expected 1", busy); else n_pass++;
    cycle(1'b0, '1, "gate_blocked2");
    idle(3);
  endtask

  task automatic test_reset_mid;
    set_ops(0, 32'hAB, 32'hCD);
    set_ops(1, 32'h12, 32'h34);
    set_ops(2, 32'h56, 32'h78);
    cycle(1'b1, '1, "mid_accept");
    issue_en  = 1'b1;
    req_valid = '1;
    reset     = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_result !== '0 || busy !== 1'b0 ||
        mul_src1 !== '0 || mul_src2 !== '0)
      $display("FAIL reset_async: ready=%b rsp_valid=%b rsp_result=%h busy=%b src1=%h src2=%h, expected all zero",
               req_ready, rsp_valid, rsp_result, busy, mul_src1, mul_src2);
    else
      n_pass++;
    sb.delete();
    ptr_model = 0;
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b0;
    idle(4);
    cycle(1'b1, '1, "rr_after_reset");
    idle(4);
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NUM_REQ; i++) set_ops(i, $urandom, $urandom);
      cycle($urandom_range(0, 4) != 0, NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)), "b2b");
    end
    idle(5);
  endtask

`ifdef MULT_ARB_PERF_CNT_EN
  task automatic test_perf;
    perf_clr = 1'b0;
    apply_reset();
    n_checks++;
    if (perf_ops !== 32'd0) $display("FAIL perf_reset: perf_ops=%0d expected 0", perf_ops); else n_pass++;
    for (int n = 0; n < 5; n++) cycle(1'b1, '1, "perf_accept");
    n_checks++;
    if (perf_ops !== 32'd5) $display("FAIL perf_count: perf_ops=%0d expected 5", perf_ops); else n_pass++;
    perf_clr = 1'b1;
    cycle(1'b1, '1, "perf_clr_accept");
    perf_clr = 1'b0;
    n_checks++;
    if (perf_ops !== 32'd0) $display("FAIL perf_clear: perf_ops=%0d expected 0", perf_ops); else n_pass++;
    cycle(1'b1, '1, "perf_after_clr");
    n_checks++;
    if (perf_ops !== 32'd1) $display("FAIL perf_incr: perf_ops=%0d expected 1", perf_ops); else n_pass++;
    idle(4);
  endtask
`endif

  initial begin
    req_src1 = '0;
    req_src2 = '0;
`ifdef MULT_ARB_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_issue_gate();
    test_reset_mid();
    test_back_to_back();
`ifdef MULT_ARB_PERF_CNT_EN
    test_perf();
`endif
    n_checks++;
    if (sb.size() != 0) $display("FAIL drain: %0d responses still outstanding", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
